// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port (fetch/data) memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RSP_IF = 2'd1,
    RSP_D  = 2'd2
  } rsp_state_e;

  // The requester ID doubles as its bit position in the request/grant vectors
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  // Byte-address bits that must be zero for an in-range word access
  function automatic logic [31:0] addr_hi_mask(input int unsigned addr_w);
    return 32'hFFFF_FFFF << (addr_w + 32'd2);
  endfunction

  function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] hi_mask);
    return ((addr[1:0] & ALIGN_MASK) == 2'b00) && ((addr & hi_mask) == 32'h0000_0000);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker; the requester not granted most recently wins a tie.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_r;

  // One-hot grant selection from the requests and the last-winner pointer
  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      gnt = 2'b00;
    end else if (req == 2'b11) begin
      gnt = (last_r == REQ_IF) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  // Pointer follows every grant; reset makes data win the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= REQ_IF;
    end else if (gnt[REQ_D]) begin
      last_r <= REQ_D;
    end else if (gnt[REQ_IF]) begin
      last_r <= REQ_IF;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory between a fetch port and a load/store port,
// one grant per cycle, response exactly one cycle after the grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rsp,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rsp,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [31:0]       mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [31:0] HI_MASK = addr_hi_mask(ADDR_W);

  logic [1:0] req_s;
  logic [1:0] gnt_s;
  logic       if_legal_s;
  logic       d_legal_s;
  rsp_state_e state_r;
  logic       err_r;
  logic       we_r;

  assign req_s = {d_req, if_req};

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (req_s),
    .gnt (gnt_s)
  );

  assign if_gnt     = gnt_s[REQ_IF];
  assign d_gnt      = gnt_s[REQ_D];
  assign if_legal_s = addr_legal(if_addr, HI_MASK);
  assign d_legal_s  = addr_legal(d_addr, HI_MASK);

  // Memory port driven by the winner; illegal requests are granted but never touch memory
  always_comb begin
    mem_addr  = 32'h0000_0000;
    mem_wdata = {DATA_W{1'b0}};
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (gnt_s[REQ_D]) begin
      mem_addr  = {{(32-ADDR_W){1'b0}}, d_addr[ADDR_W+1:2]};
      mem_wdata = d_wdata;
      mem_rd    = d_legal_s & ~d_we;
      mem_wr    = d_legal_s & d_we;
    end else if (gnt_s[REQ_IF]) begin
      mem_addr  = {{(32-ADDR_W){1'b0}}, if_addr[ADDR_W+1:2]};
      mem_rd    = if_legal_s;
    end else begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
    end
  end

  // Response owner: the state always reflects the previous cycle's grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      err_r   <= 1'b0;
      we_r    <= 1'b0;
    end else if (gnt_s[REQ_D]) begin
      state_r <= RSP_D;
      err_r   <= ~d_legal_s;
      we_r    <= d_we;
    end else if (gnt_s[REQ_IF]) begin
      state_r <= RSP_IF;
      err_r   <= ~if_legal_s;
      we_r    <= 1'b0;
    end else begin
      state_r <= IDLE;
      err_r   <= 1'b0;
      we_r    <= 1'b0;
    end
  end

  assign if_rsp   = (state_r == RSP_IF);
  assign if_err   = if_rsp & err_r;
  assign if_rdata = (if_rsp && !err_r) ? mem_rdata : {DATA_W{1'b0}};
  assign d_rsp    = (state_r == RSP_D);
  assign d_err    = d_rsp & err_r;
  assign d_rdata  = (d_rsp && !err_r && !we_r) ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter paired with a 16x32 synchronous memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rsp, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rsp, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [16];

  int vectors    = 0;
  int miscompares = 0;

  mem_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rsp    (if_rsp),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rsp     (d_rsp),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;
    mem[2] = 32'h0020_81B3;
    mem[4] = 32'h4020_81B3;
    mem_rdata = 32'h0000_0000;
  end

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[3:0]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[3:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"}, {31'b0, if_gnt}, 32'd0);
    chk({tag, "_d_gnt"},  {31'b0, d_gnt},  32'd0);
    chk({tag, "_if_rsp"}, {31'b0, if_rsp}, 32'd0);
    chk({tag, "_d_rsp"},  {31'b0, d_rsp},  32'd0);
    chk({tag, "_if_err"}, {31'b0, if_err}, 32'd0);
    chk({tag, "_d_err"},  {31'b0, d_err},  32'd0);
    chk({tag, "_mem_rd"}, {31'b0, mem_rd}, 32'd0);
    chk({tag, "_mem_wr"}, {31'b0, mem_wr}, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_d_rdata"},  d_rdata,  32'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk); #1;
    chk_all_zero("reset");

    // Release reset idle, then contention: data must win first
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("idle_no_rsp", {30'b0, if_rsp, d_rsp}, 32'd0);
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    chk("cont1_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("cont1_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("cont1_mem_rd", {31'b0, mem_rd}, 32'd1);
    chk("cont1_mem_addr", mem_addr, 32'd2);
    @(negedge clk);
    chk("cont1_d_rsp", {31'b0, d_rsp}, 32'd1);
    chk("cont1_d_rdata", d_rdata, 32'h0020_81B3);
    chk("cont1_if_rsp", {31'b0, if_rsp}, 32'd0);
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("cont2_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("cont2_mem_addr", mem_addr, 32'd4);
    @(negedge clk);
    chk("cont2_if_rsp", {31'b0, if_rsp}, 32'd1);
    chk("cont2_if_rdata", if_rdata, 32'h4020_81B3);
    chk("cont2_d_rsp", {31'b0, d_rsp}, 32'd0);

    // Fetch only at 0x8
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("fetch_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("fetch_d_gnt", {31'b0, d_gnt}, 32'd0);
    chk("fetch_mem_rd", {31'b0, mem_rd}, 32'd1);
    chk("fetch_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("fetch_mem_addr", mem_addr, 32'd2);
    @(negedge clk);
    chk("fetch_if_rsp", {31'b0, if_rsp}, 32'd1);
    chk("fetch_if_rdata", if_rdata, 32'h0020_81B3);
    chk("fetch_if_err", {31'b0, if_err}, 32'd0);

    // Store then load of word 3 back-to-back
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 32'hDEAD_BEEF);
    #1;
    chk("st_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("st_mem_wr", {31'b0, mem_wr}, 32'd1);
    chk("st_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("st_mem_addr", mem_addr, 32'd3);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("st_d_rsp", {31'b0, d_rsp}, 32'd1);
    chk("st_d_err", {31'b0, d_err}, 32'd0);
    chk("st_d_rdata", d_rdata, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0);
    #1;
    chk("ld_mem_rd", {31'b0, mem_rd}, 32'd1);
    chk("ld_mem_wr", {31'b0, mem_wr}, 32'd0);
    @(negedge clk);
    chk("ld_d_rsp", {31'b0, d_rsp}, 32'd1);
    chk("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);

    // Misaligned data load, then out-of-range fetch
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h6, 32'h0);
    #1;
    chk("mis_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("mis_mem_strb", {30'b0, mem_rd, mem_wr}, 32'd0);
    @(negedge clk);
    chk("mis_d_rsp", {31'b0, d_rsp}, 32'd1);
    chk("mis_d_err", {31'b0, d_err}, 32'd1);
    chk("mis_d_rdata", d_rdata, 32'h0);
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("oor_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("oor_mem_strb", {30'b0, mem_rd, mem_wr}, 32'd0);
    @(negedge clk);
    chk("oor_if_rsp", {31'b0, if_rsp}, 32'd1);
    chk("oor_if_err", {31'b0, if_err}, 32'd1);
    chk("oor_if_rdata", if_rdata, 32'h0);
    chk("oor_d_err", {31'b0, d_err}, 32'd0);

    // Both held for 6 cycles: D, IF, D, IF, D, IF
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("alt_d_gnt", {31'b0, d_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_if_gnt", {31'b0, if_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
      @(negedge clk);
      chk("alt_rsp_pair", {30'b0, if_rsp, d_rsp}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("alt_rdata", (i % 2 == 0) ? d_rdata : if_rdata,
          (i % 2 == 0) ? 32'h4020_81B3 : 32'h0020_81B3);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset in the response cycle discards the response and restores data priority
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    chk("pre_rst_d_gnt", {31'b0, d_gnt}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_no_rsp", {30'b0, if_rsp, d_rsp}, 32'd0);
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk("post_rst_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("post_rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("post_rst_d_rsp", {31'b0, d_rsp}, 32'd1);
    chk("post_rst_d_rdata", d_rdata, 32'h4020_81B3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 4, word-index width of the shared memory (16 words).
- DATA_W, 32, data width.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- if_req, in, 1, instruction-fetch read request.
- if_addr, in, 32, fetch byte address.
- if_gnt, out, 1, fetch request accepted this cycle.
- if_rsp, out, 1, fetch response valid.
- if_rdata, out, DATA_W, fetch read data.
- if_err, out, 1, fetch response is an error.
- d_req, in, 1, data (load/store) request.
- d_we, in, 1, 1 = store, 0 = load.
- d_addr, in, 32, data byte address.
- d_wdata, in, DATA_W, store data.
- d_gnt, out, 1, data request accepted this cycle.
- d_rsp, out, 1, data response valid (loads and stores).
- d_rdata, out, DATA_W, load data.
- d_err, out, 1, data response is an error.
- mem_addr, out, 32, memory word index.
- mem_rd, out, 1, memory read strobe.
- mem_wr, out, 1, memory write strobe.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory registered read data, valid 1 cycle after mem_rd.

Function
REQ-003 The block SHALL accept at most one request per cycle, in any state, giving a throughput of 1 transaction/cycle.
REQ-004 Grant behaviour:
- gnt SHALL be combinational from req and the arbitration pointer.
- A requester whose req is high while gnt is low SHALL hold req, address and data stable.
REQ-005 Arbitration:
- Only one requester high: that requester SHALL win.
- Both high: the requester not granted most recently SHALL win.
- The pointer SHALL update to the winner on every grant.
REQ-006 Address decode:
- Word index SHALL be addr[ADDR_W+1:2], zero-extended to 32 bits on mem_addr.
- The request is illegal if addr[1:0] != 0 or addr[31:ADDR_W+2] != 0.
REQ-007 Legal granted request: mem_rd (load or fetch) or mem_wr (store) SHALL be asserted in the grant cycle, with mem_addr and mem_wdata driven from the winner.
REQ-008 Illegal granted request: it SHALL be granted without asserting mem_rd or mem_wr.
REQ-009 With no grant, mem_rd = mem_wr = 0; mem_addr and mem_wdata are don't-care.
REQ-010 Response owner FSM:
- States: IDLE, RSP_IF, RSP_D.
- A grant moves the FSM to RSP_IF or RSP_D; no grant moves it to IDLE.
- The move happens from any state.
- A registered error flag and a registered we flag SHALL accompany the state.
REQ-011 In RSP_IF, if_rsp = 1 and if_err = the stored error flag.
- if_rdata SHALL equal mem_rdata when there is no error, else 0.
REQ-012 In RSP_D, d_rsp = 1 and d_err = the stored error flag.
- d_rdata SHALL equal mem_rdata for a legal load, else 0.
- Stores SHALL receive a d_rsp pulse.
REQ-013 Response latency SHALL be exactly 1 cycle after grant; back-to-back grants SHALL produce back-to-back responses in grant order.
REQ-014 if_rsp and d_rsp SHALL never be high in the same cycle; the err outputs SHALL be 0 whenever the matching rsp is 0.
REQ-015 The fetch port is read-only and carries no write signals.

Reset
REQ-016 While rst is high:
- FSM SHALL be IDLE, pointer = "fetch last granted" (data wins the first contention), flags = 0.
- All rsp, err, gnt, mem_rd and mem_wr outputs SHALL be 0; rdata outputs SHALL be 0.
REQ-017 Reset asserted in a response cycle SHALL discard the pending response; no rsp SHALL appear after release until a new grant.

Structure
REQ-018 A shared package SHALL hold:
- the FSM state encoding (IDLE, RSP_IF, RSP_D);
- the requester ID constants;
- the address-legality constants derived from ADDR_W.
REQ-019 The round-robin picker SHALL be a single sub-module, rr_arb2: 2 requests in, 2 one-hot grants out, pointer register inside, with clk and rst.
REQ-020 The response-owner FSM, flags and memory-port mux SHALL live in mem_arbiter; no other sub-modules.

Verification
REQ-021 The bench SHALL pair the arbiter with a 16x32 synchronous memory model preloaded with word[2] = 0x002081B3 and word[4] = 0x402081B3, and SHALL cover these directed scenarios:
- Fetch only, if_addr = 0x8 -> if_gnt same cycle; next cycle if_rsp = 1, if_rdata = 0x002081B3, if_err = 0.
- Both request after reset (if_addr = 0x10, d load at 0x8) -> data wins first and returns 0x002081B3; fetch wins the next cycle and returns 0x402081B3.
- Store 0xDEADBEEF to 0xC then load 0xC back-to-back -> mem_wr then mem_rd in consecutive cycles; d_rsp pulses both cycles; second d_rdata = 0xDEADBEEF.
- Misaligned d_addr = 0x6 and out-of-range if_addr = 0x40 -> gnt given, mem_rd = mem_wr = 0, error response 1 cycle later with rdata = 0.
- Both held high for 6 cycles -> grants alternate D, IF, D, IF, D, IF; responses follow 1 cycle later with no overlap.
- rst pulsed in the cycle after a grant -> no rsp appears; all outputs are 0 during reset; the first post-reset contention goes to data.
